// File: rtl/hdb3_tx_sched.sv
// rtl/hdb3_tx_sched.sv - byte-to-serial frame scheduler feeding an HDB3 encoder
// Optional preamble build: define HDB3_TX_PREAMBLE_EN
module hdb3_tx_sched #(
  parameter int unsigned LATENCY  = 4,
  parameter logic        FILL_BIT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  output logic       o_byte_ready,
  output logic       o_ser_data,
  output logic       o_ser_en,
  output logic       o_code_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_underrun
);

  localparam int unsigned FW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_XMIT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     sr_q, sr_d;             // bits still to go after the one on the line
  logic [2:0]     bit_idx_q, bit_idx_d;   // index of the bit currently on the line
  logic           have_q, have_d;         // a payload byte is on the line
  logic [7:0]     rem_q, rem_d;           // bytes not yet accepted
  logic           any_q, any_d;           // a byte was accepted in this frame
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic           ser_data_q, ser_data_d;
  logic           ser_en_q, ser_en_d;
  logic           underrun_q, underrun_d;
  logic [LATENCY-1:0] dly_q, dly_d;
  logic           accept;

  // Byte handshake: ready only depends on registered state
  assign o_byte_ready = (state_q == S_XMIT) && (rem_q != 8'd0) &&
                        (!have_q || (bit_idx_q == 3'd0));
  assign accept       = o_byte_ready && i_byte_valid;

  assign o_ser_data   = ser_data_q;
  assign o_ser_en     = ser_en_q;
  assign o_code_valid = dly_q[LATENCY-1];
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_underrun   = underrun_q;

  // Next-state and next line bit; the line bit is registered so an accepted
  // byte's MSB follows the previous bit without a gap
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_idx_d   = bit_idx_q;
    have_d      = have_q;
    rem_d       = rem_q;
    any_d       = any_q;
    flush_cnt_d = flush_cnt_q;
    ser_data_d  = FILL_BIT;
    ser_en_d    = 1'b0;
    underrun_d  = underrun_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rem_d       = i_len;
          have_d      = 1'b0;
          bit_idx_d   = 3'd0;
          any_d       = 1'b0;
          underrun_d  = 1'b0;
          flush_cnt_d = '0;
          if (i_len == 8'd0) begin
            state_d = S_DONE;
          end else begin
`ifdef HDB3_TX_PREAMBLE_EN
            state_d   = S_PRE;
            bit_idx_d = 3'd7;
`else
            state_d   = S_XMIT;
`endif
          end
        end
      end
`ifdef HDB3_TX_PREAMBLE_EN
      S_PRE: begin
        ser_en_d   = 1'b1;
        ser_data_d = bit_idx_q[0];
        if (bit_idx_q == 3'd0) begin
          state_d = S_XMIT;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end
      end
`endif
      S_XMIT: begin
        ser_en_d = 1'b1;
        if (have_q && (bit_idx_q != 3'd0)) begin
          ser_data_d = sr_q[6];
          sr_d       = {sr_q[5:0], 1'b0};
          bit_idx_d  = bit_idx_q - 3'd1;
        end else if (accept) begin
          ser_data_d = i_byte[7];
          sr_d       = i_byte[6:0];
          bit_idx_d  = 3'd7;
          have_d     = 1'b1;
          rem_d      = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
          any_d      = 1'b1;
        end else if (rem_q == 8'd0) begin
          ser_en_d    = 1'b0;
          have_d      = 1'b0;
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else begin
          have_d = 1'b0;
          if (any_q) begin
            underrun_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FW'(LATENCY - 1)) begin
          state_d = S_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Code-valid delay line tracks the line enable in every state
  always_comb begin
    dly_d    = dly_q << 1;
    dly_d[0] = ser_en_q;
  end

  // State register with asynchronous abort
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_idx_q   <= 3'd0;
      have_q      <= 1'b0;
      rem_q       <= 8'd0;
      any_q       <= 1'b0;
      flush_cnt_q <= '0;
      ser_data_q  <= FILL_BIT;
      ser_en_q    <= 1'b0;
      underrun_q  <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_idx_q   <= bit_idx_d;
      have_q      <= have_d;
      rem_q       <= rem_d;
      any_q       <= any_d;
      flush_cnt_q <= flush_cnt_d;
      ser_data_q  <= ser_data_d;
      ser_en_q    <= ser_en_d;
      underrun_q  <= underrun_d;
      dly_q       <= dly_d;
    end
  end

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// tb/tb_hdb3_tx_sched.sv - scoreboard bench for hdb3_tx_sched
module tb_hdb3_tx_sched;
  localparam int   LAT  = 4;
  localparam logic FILL = 1'b1;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start, i_byte_valid;
  logic [7:0] i_len, i_byte;
  logic       o_byte_ready, o_ser_data, o_ser_en, o_code_valid, o_busy, o_done, o_underrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit uf_m = 1'b0;

  bit exp_bits[$];
  int exp_done[$];
  bit en_at[int];
  bit uf_at[int];
  bit busy_at[int];

  hdb3_tx_sched #(.LATENCY(LAT), .FILL_BIT(FILL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .o_ser_data(o_ser_data), .o_ser_en(o_ser_en), .o_code_valid(o_code_valid),
    .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the line against the expectations queued by the driver
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      chk("ser_en", o_ser_en, en_at.exists(cyc));
      chk("code_valid", o_code_valid, en_at.exists(cyc - LAT));
      if (!o_ser_en) chk("line_fill", o_ser_data, FILL);
      if (uf_at.exists(cyc)) chk("underrun", o_underrun, uf_at[cyc]);
      if (busy_at.exists(cyc)) chk("busy", o_busy, busy_at[cyc]);
      if (o_ser_en) begin
        if (exp_bits.size() == 0) chk("ser_bit_unexpected", o_ser_en, 0);
        else chk("ser_bit", o_ser_data, exp_bits.pop_front());
      end
      if (o_done) begin
        if (exp_done.size() == 0) chk("done_unexpected", o_done, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic drive(input logic st, input logic [7:0] ln, input logic v,
                       input logic [7:0] b, input bit busy, input bit rdy);
    chk("byte_ready", o_byte_ready, rdy);
    i_start = st; i_len = ln; i_byte_valid = v; i_byte = b;
    busy_at[cyc] = busy;
  endtask

  task automatic emit(input bit b);
    en_at[cyc + 1] = 1'b1;
    exp_bits.push_back(b);
  endtask

  task automatic next_cycle();
    uf_at[cyc + 1] = uf_m;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 8'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
      next_cycle();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_ser_data", o_ser_data, 1'b1);
    chk("rst_ser_en", o_ser_en, 0);
    chk("rst_code_valid", o_code_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_byte_ready", o_byte_ready, 0);
    exp_bits.delete(); exp_done.delete(); en_at.delete(); uf_at.delete(); busy_at.delete();
    uf_m = 1'b0;
    i_start = 1'b0; i_byte_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // One frame: the model keeps the bits of the byte in flight as a queue
  task automatic run_frame(input int len, input int prob, input int hold0, input int hold1,
                           input int nfix, input logic [7:0] b0, input logic [7:0] b1,
                           input int abort_at);
    int remaining = len;
    int acc = 0;
    int ready_low = 0;
    int xcnt = 0;
    int hold;
    bit any = 1'b0;
    bit rdy;
    logic v;
    logic [7:0] by;
    bit pend[$];
    drive(1'b1, 8'(len), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
    uf_m = 1'b0;
    next_cycle();
    if (len == 0) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
      exp_done.push_back(cyc);
      next_cycle();
      return;
    end
`ifdef HDB3_TX_PREAMBLE_EN
    for (int k = 0; k < 8; k++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
      emit((k % 2) == 0);
      next_cycle();
    end
`endif
    forever begin
      if (xcnt == abort_at) begin
        do_reset();
        return;
      end
      xcnt++;
      rdy = (remaining > 0) && (pend.size() == 0);
      v = 1'($urandom);
      if (rdy) begin
        hold = (acc == 0) ? hold0 : ((acc == 1) ? hold1 : 0);
        v = (ready_low < hold) ? 1'b0 : ($urandom_range(99) < prob);
        if (!v) ready_low++;
      end
      by = (acc == 0 && nfix > 0) ? b0 : ((acc == 1 && nfix > 1) ? b1 : 8'($urandom));
      drive(($urandom_range(3) == 0), 8'($urandom), v, by, 1'b1, rdy);
      if (rdy && v) begin
        for (int k = 7; k >= 0; k--) pend.push_back(by[k]);
        remaining--; acc++; any = 1'b1; ready_low = 0;
        emit(pend.pop_front());
      end else if (pend.size() > 0) begin
        emit(pend.pop_front());
      end else if (remaining == 0) begin
        next_cycle();
        break;
      end else begin
        emit(FILL);
        if (any) uf_m = 1'b1;
      end
      next_cycle();
    end
    repeat (LAT) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
      next_cycle();
    end
    drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
    exp_done.push_back(cyc);
    next_cycle();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = 8'd0; i_byte_valid = 1'b0; i_byte = 8'd0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_ser_data", o_ser_data, 1'b1);
    chk("reset_ser_en", o_ser_en, 0);
    chk("reset_code_valid", o_code_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_underrun", o_underrun, 0);
    chk("reset_byte_ready", o_byte_ready, 0);
    i_rst = 1'b0;
    mon_en = 1'b1;
    idle(3);
    run_frame(2, 100, 0, 0, 2, 8'hA5, 8'h0F, -1);
    idle(2);
    run_frame(1, 100, 3, 0, 1, 8'h00, 8'h00, -1);
    idle(2);
    run_frame(2, 100, 0, 2, 0, 8'h00, 8'h00, -1);
    idle(4);
    run_frame(0, 100, 0, 0, 0, 8'h00, 8'h00, -1);
    idle(2);
    run_frame(1, 100, 0, 0, 1, 8'hFF, 8'h00, -1);
    idle(2);
    run_frame(3, 100, 0, 0, 0, 8'h00, 8'h00, 4);
    idle(LAT + 3);
    run_frame(1, 100, 0, 0, 1, 8'h3C, 8'h00, -1);
    idle(2);
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(5), $urandom_range(30, 100), $urandom_range(2),
                $urandom_range(2), 0, 8'h00, 8'h00, -1);
      idle($urandom_range(3));
    end
    idle(LAT + 3);
    chk("bits_left", exp_bits.size(), 0);
    chk("done_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
